// File: rtl/morse_pkg.sv
// Shared FSM state type, the invalid-letter code and the Morse-to-letter lookup.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_DECODE,
    ST_SHOW
  } state_t;

  localparam logic [4:0] INVALID_CODE = 5'd31;

  // Pattern holds elements right-aligned, first element in the highest valid bit, dash = 1.
  function automatic logic [4:0] morse_lookup(input logic [2:0] count, input logic [3:0] pattern);
    logic [4:0] idx;
    idx = INVALID_CODE;
    case ({count, pattern})
      {3'd1, 4'b0000}: idx = 5'd4;   // E
      {3'd1, 4'b0001}: idx = 5'd19;  // T
      {3'd2, 4'b0000}: idx = 5'd8;   // I
      {3'd2, 4'b0001}: idx = 5'd0;   // A
      {3'd2, 4'b0010}: idx = 5'd13;  // N
      {3'd2, 4'b0011}: idx = 5'd12;  // M
      {3'd3, 4'b0000}: idx = 5'd18;  // S
      {3'd3, 4'b0001}: idx = 5'd20;  // U
      {3'd3, 4'b0010}: idx = 5'd17;  // R
      {3'd3, 4'b0011}: idx = 5'd22;  // W
      {3'd3, 4'b0100}: idx = 5'd3;   // D
      {3'd3, 4'b0101}: idx = 5'd10;  // K
      {3'd3, 4'b0110}: idx = 5'd6;   // G
      {3'd3, 4'b0111}: idx = 5'd14;  // O
      {3'd4, 4'b1000}: idx = 5'd1;   // B
      {3'd4, 4'b1010}: idx = 5'd2;   // C
      {3'd4, 4'b0010}: idx = 5'd5;   // F
      {3'd4, 4'b0000}: idx = 5'd7;   // H
      {3'd4, 4'b0111}: idx = 5'd9;   // J
      {3'd4, 4'b0100}: idx = 5'd11;  // L
      {3'd4, 4'b0110}: idx = 5'd15;  // P
      {3'd4, 4'b1101}: idx = 5'd16;  // Q
      {3'd4, 4'b0001}: idx = 5'd21;  // V
      {3'd4, 4'b1001}: idx = 5'd23;  // X
      {3'd4, 4'b1011}: idx = 5'd24;  // Y
      {3'd4, 4'b1100}: idx = 5'd25;  // Z
      default:         idx = INVALID_CODE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module morse_tick_gen
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/morse_symbol_ctrl.sv
// Morse key decoder: classifies marks as dot/dash, ends a letter on a long space,
// and presents the decoded letter index to the seven-segment decoder.
module morse_symbol_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int DASH_TICKS = 200,
  parameter int GAP_TICKS  = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [4:0] morse_in,
  output logic       inp,
  output logic       busy
);

  localparam logic [9:0] DUR_MAX = 10'd1023;
  localparam logic [9:0] DASH_L  = 10'(DASH_TICKS);
  localparam logic [9:0] GAP_L   = 10'(GAP_TICKS);

  logic [1:0] sync_reg;
  logic       ks;
  logic       tick;
  state_t     state_reg;
  logic [9:0] dur_reg;
  logic [2:0] count_reg;
  logic [3:0] pattern_reg;
  logic [4:0] morse_in_reg;
  logic       inp_reg;
  logic       busy_reg;

  assign ks = sync_reg[1];

  morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg     <= 2'b00;
      state_reg    <= ST_IDLE;
      dur_reg      <= '0;
      count_reg    <= '0;
      pattern_reg  <= '0;
      morse_in_reg <= INVALID_CODE;
      inp_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], key};
      if (tick && dur_reg != DUR_MAX) begin
        dur_reg <= dur_reg + 10'd1;
      end
      case (state_reg)
        ST_IDLE, ST_SHOW: begin
          if (ks) begin
            state_reg   <= ST_MARK;
            dur_reg     <= '0;
            count_reg   <= '0;
            pattern_reg <= '0;
            inp_reg     <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        ST_MARK: begin
          // A saturated duration still compares as a dash.
          if (!ks) begin
            state_reg   <= ST_SPACE;
            dur_reg     <= '0;
            pattern_reg <= {pattern_reg[2:0], (dur_reg >= DASH_L)};
            count_reg   <= (count_reg == 3'd5) ? 3'd5 : count_reg + 3'd1;
          end
        end
        ST_SPACE: begin
          // The gap takes priority over a press arriving on the same cycle.
          if (dur_reg == GAP_L) begin
            state_reg <= ST_DECODE;
            dur_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (ks) begin
            state_reg <= ST_MARK;
            dur_reg   <= '0;
          end
        end
        ST_DECODE: begin
          state_reg    <= ST_SHOW;
          dur_reg      <= '0;
          morse_in_reg <= morse_lookup(count_reg, pattern_reg);
          inp_reg      <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          dur_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign morse_in = morse_in_reg;
  assign inp      = inp_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_morse_symbol_ctrl.sv
// Directed bench for morse_symbol_ctrl with short timing (TICK_DIV=4, DASH=3, GAP=8).
module tb_morse_symbol_ctrl;
  import morse_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key = 1'b0;
  logic [4:0] morse_in;
  logic       inp;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  morse_symbol_ctrl #(.TICK_DIV(4), .DASH_TICKS(3), .GAP_TICKS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .morse_in (morse_in),
    .inp      (inp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic press(input int ticks);
    key = 1'b1;
    repeat (ticks * TD) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic gap(input int ticks);
    key = 1'b0;
    repeat (ticks * TD) @(negedge clk);
  endtask

  // Release the key, wait for DECODE, then check inp rises exactly one cycle later.
  task automatic expect_letter(input string name, input logic [4:0] exp);
    bit found = 1'b0;
    key = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(negedge clk);
      if (dut.state_reg == ST_DECODE) found = 1'b1;
    end
    vec_cnt++;
    if (!found) begin
      $display("FAIL %s decode_timeout: no DECODE within 150 cycles", name);
      err_cnt++;
    end else begin
      vec_cnt++;
      if (inp !== 1'b0) begin
        $display("FAIL %s inp_on_decode: got %b want 0", name, inp);
        err_cnt++;
      end
      @(negedge clk);
      vec_cnt++;
      if (inp !== 1'b1) begin
        $display("FAIL %s inp_after_decode: got %b want 1", name, inp);
        err_cnt++;
      end
      vec_cnt++;
      if (morse_in !== exp) begin
        $display("FAIL %s morse_in: got %0d want %0d", name, morse_in, exp);
        err_cnt++;
      end
      vec_cnt++;
      if (busy !== 1'b0) begin
        $display("FAIL %s busy_in_show: got %b want 0", name, busy);
        err_cnt++;
      end
    end
    $display("letter %s: morse_in=%0d inp=%b (expected %0d)", name, morse_in, inp, exp);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (morse_in !== INVALID_CODE || inp !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_outputs: got %0d/%b/%b want 31/0/0", morse_in, inp, busy);
      err_cnt++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b want 0", busy);
      err_cnt++;
    end
    $display("reset: morse_in=%0d inp=%b busy=%b", morse_in, inp, busy);
  endtask

  task automatic test_a();
    press(1); gap(2); press(4);
    expect_letter("A", 5'd0);
  endtask

  task automatic test_o_and_drop();
    int n = 0;
    bit dropped = 1'b0;
    press(4); gap(2); press(4); gap(2); press(4);
    expect_letter("O", 5'd14);
    key = 1'b1;
    for (int i = 0; i < 4 && !dropped; i++) begin
      @(negedge clk);
      n++;
      if (inp === 1'b0) dropped = 1'b1;
    end
    vec_cnt++;
    if (!dropped) begin
      $display("FAIL inp_drop: inp still %b after %0d cycles, want 0 within 4", inp, n);
      err_cnt++;
    end
    @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_in_mark: got %b want 1", busy);
      err_cnt++;
    end
    $display("press after O: inp dropped in %0d cycles, busy=%b", n, busy);
    repeat (2) @(negedge clk);
    expect_letter("E_after_O", 5'd4);
  endtask

  task automatic test_five_dots();
    for (int i = 0; i < 5; i++) begin
      press(1);
      if (i < 4) gap(2);
    end
    expect_letter("five_dots", INVALID_CODE);
  endtask

  task automatic test_back_to_back();
    press(1);
    expect_letter("E", 5'd4);
    press(4);
    expect_letter("T", 5'd19);
  endtask

  task automatic test_reset_mid_mark();
    key = 1'b1;
    repeat (8) @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b1) begin
      $display("FAIL pre_reset_busy: got %b want 1", busy);
      err_cnt++;
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (morse_in !== INVALID_CODE || inp !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL async_reset: got %0d/%b/%b want 31/0/0", morse_in, inp, busy);
      err_cnt++;
    end
    $display("mid-mark reset: morse_in=%0d inp=%b busy=%b", morse_in, inp, busy);
    key = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    press(1);
    expect_letter("E_after_reset", 5'd4);
  endtask

  task automatic test_long_press();
    key = 1'b1;
    repeat (1100 * TD) @(negedge clk);
    vec_cnt++;
    if (dut.dur_reg !== 10'd1023) begin
      $display("FAIL dur_saturate: got %0d want 1023", dut.dur_reg);
      err_cnt++;
    end
    vec_cnt++;
    if (busy !== 1'b1) begin
      $display("FAIL long_busy: got %b want 1", busy);
      err_cnt++;
    end
    $display("long press: duration=%0d busy=%b", dut.dur_reg, busy);
    expect_letter("long_T", 5'd19);
  endtask

  initial begin
    test_reset();
    test_a();
    test_o_and_drop();
    test_five_dots();
    test_back_to_back();
    test_reset_mid_mark();
    test_long_press();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/morse_symbol_ctrl.md
MORSE_SYMBOL_CTRL -- requirements
Module: morse_symbol_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, is the clock cycles per timing tick (1 ms at 50 MHz).
REQ-002 Parameter DASH_TICKS, default 200, is the minimum mark length in ticks classified as dash.
REQ-003 Parameter GAP_TICKS, default 600, is the space length in ticks that ends a letter.
REQ-004 Port clk  input  1  is the single system clock; all state SHALL be rising-edge clocked.
REQ-005 Port rst  input  1  is the asynchronous, active-low reset.
REQ-006 Port key  input  1  is the raw Morse key, 1 = pressed, asynchronous to clk.
REQ-007 Port morse_in  output  5  is the registered letter index, 0 = A through 25 = Z, 31 = invalid; it feeds the seven-segment decoder.
REQ-008 Port inp  output  1  is the registered display-valid level for the seven-segment decoder.
REQ-009 Port busy  output  1  SHALL be 1 while a letter is being keyed (MARK or SPACE state).

Function
REQ-010 key SHALL pass through a 2-flop synchronizer; all behaviour below uses the synchronized key (ks), which lags key by 2 cycles.
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 and emit a 1-cycle tick on wrap; it free-runs and resets only on rst.
REQ-012 The duration counter SHALL be 10 bits, SHALL increment on tick, SHALL saturate at 1023, and SHALL clear on every state entry.
REQ-013 The FSM SHALL have the states IDLE, MARK, SPACE, DECODE and SHOW.
REQ-014 IDLE or SHOW with ks=1 -> MARK; entry SHALL clear the element count and pattern and SHALL drive inp=0 from the next cycle.
REQ-015 MARK with ks=0 -> SPACE; the element SHALL be dash if duration >= DASH_TICKS, else dot.
REQ-016 On each element, pattern SHALL become {pattern[2:0], is_dash} (first element ends up as the most significant valid bit) and the count SHALL increment, saturating at 5.
REQ-017 SPACE with ks=1 before GAP_TICKS -> MARK, keeping the element count and pattern.
REQ-018 SPACE with duration == GAP_TICKS -> DECODE.
REQ-019 DECODE SHALL last exactly 1 cycle, then go to SHOW.
REQ-020 On the DECODE cycle, morse_in SHALL be registered from the lookup of (count, pattern); inp SHALL be 1 from the following cycle.
REQ-021 Lookup: count 1..4 matching the International Morse letter code SHALL give its index; count 0, count 5 or an unused 4-element code SHALL give 31.
REQ-022 SHOW SHALL hold morse_in and inp=1 indefinitely until ks=1.
REQ-023 If ks rises on the same cycle that duration reaches GAP_TICKS, the gap SHALL win: the FSM goes to DECODE, and the press is taken from SHOW one cycle later.
REQ-024 A mark longer than 1023 ticks SHALL be classified as dash, with no error raised.

Reset
REQ-025 While rst=0: state=IDLE, morse_in=31, inp=0, busy=0, prescaler=0, duration=0, count=0, pattern=0, synchronizer flops=0.
REQ-026 Reset asserted mid-letter SHALL discard the partial letter; after release the FSM SHALL start in IDLE and ignore a held key until ks is seen at 1 (it then enters MARK normally).

Structure
REQ-027 Package morse_pkg SHALL hold the FSM state enum, the INVALID_CODE=31 constant and the letter lookup function.
REQ-028 Sub-module morse_tick_gen (the prescaler) SHALL be instantiated once; the lookup SHALL stay combinational in the package.

Verification (TICK_DIV=4, DASH_TICKS=3, GAP_TICKS=8)
REQ-029 Bench scenario "A": dot (press 1 tick), gap 2 ticks, dash (press 4 ticks), release 8 ticks -> morse_in=0, inp=1 one cycle after DECODE.
REQ-030 Bench scenario "O": three 4-tick presses with 2-tick gaps, then release -> morse_in=14; a later press drops inp to 0 within 4 cycles of key rising.
REQ-031 Bench scenario five dots then gap -> morse_in=31, inp=1.
REQ-032 Bench scenario "E" then "T" (1-tick press, 8-tick gap, 4-tick press, gap) -> morse_in 4 then 19.
REQ-033 Bench scenario rst pulsed low mid-MARK -> outputs 31/0/0 immediately (async); a fresh "E" afterwards decodes to 4.
REQ-034 Bench scenario 1100-tick press then gap -> dash, morse_in=19, counter stuck at 1023 without wrap.
